multi_or_reduce: RTL and testbench

- Parametrised, pipelined successor to the fixed 4-input OR wrapper.
- Reduces an N_IN-bit vector to one bit through a tree of 4-input reduction cells, with mask, selectable mode, a valid pipeline and a sticky accumulator.
- Sits between status/flag collectors and control FSMs that need "any/all/parity of these flags" with registered timing.

---
 rtl/multi_or_reduce_if.sv | 25 ++
 rtl/multi_or_reduce.sv | 106 ++++++++++
 tb/tb_multi_or_reduce.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/multi_or_reduce_if.sv
// Request/result bundle for multi_or_reduce: sampled vector, mask and mode in,
// one-bit reduction result and sticky accumulator out.
interface multi_or_reduce_if #(
    parameter int unsigned N_IN = 16
);
    logic            in_valid;
    logic [N_IN-1:0] in_data;
    logic [N_IN-1:0] in_mask;
    logic [1:0]      mode;
    logic            acc_en;
    logic            acc_clr;
    logic            out_valid;
    logic            out;
    logic            acc_out;

    modport master (
        output in_valid, in_data, in_mask, mode, acc_en, acc_clr,
        input  out_valid, out, acc_out
    );

    modport slave (
        input  in_valid, in_data, in_mask, mode, acc_en, acc_clr,
        output out_valid, out, acc_out
    );
endinterface

// File: rtl/multi_or_reduce.sv
// Masked OR/AND/XOR/NOR reduction of an N_IN-bit vector through a 4-ary tree,
// optionally registered per level, with a sticky OR accumulator on the result.
module multi_or_reduce #(
    parameter int unsigned N_IN = 16,
    parameter int unsigned PIPE = 1
) (
    input logic            clk,
    input logic            rst,
    multi_or_reduce_if.slave bus
);
    typedef enum logic [1:0] {
        MODE_OR  = 2'b00,
        MODE_AND = 2'b01,
        MODE_XOR = 2'b10,
        MODE_NOR = 2'b11
    } mode_e;

    function automatic int unsigned calc_levels(input int unsigned n);
        int unsigned lvl;
        int unsigned span;
        lvl  = 1;
        span = 4;
        while (span < n) begin
            span = span * 4;
            lvl++;
        end
        return lvl;
    endfunction

    localparam int unsigned LEVELS = calc_levels(N_IN);
    localparam int unsigned LAST   = LEVELS - 1;

    // NOR runs as an OR tree; inversion happens only at the output register.
    function automatic logic red_group(input logic [3:0] d, input mode_e m);
        case (m)
            MODE_AND: return &d;
            MODE_XOR: return ^d;
            default:  return |d;
        endcase
    endfunction

    // Stage k holds the 4^(LEVELS-k) inputs of tree level k; the input is
    // padded up to a full power of four with the mode's identity element.
    for (genvar k = 0; k < LEVELS; k++) begin : g_stage
        localparam int unsigned W = 1 << (2 * (LEVELS - k));
        logic [W-1:0] data;
        mode_e        md;
        logic         vld;

        if (k == 0) begin : g_in
            always_comb begin
                md   = mode_e'(bus.mode);
                vld  = bus.in_valid;
                data = {W{md == MODE_AND}};
                for (int unsigned i = 0; i < N_IN; i++) begin
                    if (bus.in_mask[i]) data[i] = bus.in_data[i];
                end
            end
        end else if (PIPE != 0) begin : g_reg
            always_ff @(posedge clk) begin
                if (rst) begin
                    data <= '0;
                    md   <= MODE_OR;
                    vld  <= 1'b0;
                end else begin
                    for (int unsigned g = 0; g < W; g++) begin
                        data[g] <= red_group(g_stage[k-1].data[4*g +: 4], g_stage[k-1].md);
                    end
                    md  <= g_stage[k-1].md;
                    vld <= g_stage[k-1].vld;
                end
            end
        end else begin : g_comb
            always_comb begin
                data = '0;
                for (int unsigned g = 0; g < W; g++) begin
                    data[g] = red_group(g_stage[k-1].data[4*g +: 4], g_stage[k-1].md);
                end
                md  = g_stage[k-1].md;
                vld = g_stage[k-1].vld;
            end
        end
    end

    // Accumulator acts on the result already visible on out/out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out       <= 1'b0;
            bus.acc_out   <= 1'b0;
        end else begin
            bus.out_valid <= g_stage[LAST].vld;
            if (g_stage[LAST].vld) begin
                bus.out <= red_group(g_stage[LAST].data, g_stage[LAST].md)
                           ^ (g_stage[LAST].md == MODE_NOR);
            end
            if (bus.acc_clr && bus.out_valid && bus.acc_en) begin
                bus.acc_out <= bus.out;
            end else if (bus.acc_clr) begin
                bus.acc_out <= 1'b0;
            end else if (bus.out_valid && bus.acc_en) begin
                bus.acc_out <= bus.acc_out | bus.out;
            end
        end
    end
endmodule

// File: tb/tb_multi_or_reduce.sv
// Bench for multi_or_reduce: N_IN=16/PIPE=1 and N_IN=5/PIPE=0 instances checked
// every cycle against a counting reference model with a timed result queue.
module tb_multi_or_reduce;
    localparam int LAT_A = 2;
    localparam int LAT_B = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multi_or_reduce_if #(.N_IN(16)) bus_a ();
    multi_or_reduce_if #(.N_IN(5))  bus_b ();

    multi_or_reduce #(.N_IN(16), .PIPE(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    multi_or_reduce #(.N_IN(5),  .PIPE(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    typedef struct {
        int due;
        bit val;
    } pending_t;

    pending_t qa[$];
    pending_t qb[$];
    bit exp_vld_a, exp_out_a, exp_acc_a;
    bit exp_vld_b, exp_out_b, exp_acc_b;
    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reduction by counting active and set bits; no tree involved.
    function automatic bit ref_reduce(input logic [15:0] d, input logic [15:0] m,
                                      input int n, input logic [1:0] md);
        int act = 0;
        int cnt = 0;
        for (int i = 0; i < n; i++) begin
            if (m[i]) begin
                act++;
                if (d[i]) cnt++;
            end
        end
        case (md)
            2'd0:    return cnt > 0;
            2'd1:    return cnt == act;
            2'd2:    return (cnt % 2) == 1;
            default: return cnt == 0;
        endcase
    endfunction

    function automatic bit acc_next(input bit acc, input bit vld, input bit o,
                                    input bit en, input bit clr);
        if (clr && vld && en) return o;
        if (clr) return 1'b0;
        if (vld && en) return acc | o;
        return acc;
    endfunction

    task automatic tick();
        if (rst) begin
            qa.delete();
            qb.delete();
            {exp_vld_a, exp_out_a, exp_acc_a} = '0;
            {exp_vld_b, exp_out_b, exp_acc_b} = '0;
        end else begin
            exp_acc_a = acc_next(exp_acc_a, exp_vld_a, exp_out_a, bus_a.acc_en, bus_a.acc_clr);
            exp_acc_b = acc_next(exp_acc_b, exp_vld_b, exp_out_b, bus_b.acc_en, bus_b.acc_clr);
            if (bus_a.in_valid)
                qa.push_back('{cyc + LAT_A, ref_reduce(bus_a.in_data, bus_a.in_mask, 16, bus_a.mode)});
            if (bus_b.in_valid)
                qb.push_back('{cyc + LAT_B, ref_reduce({11'b0, bus_b.in_data}, {11'b0, bus_b.in_mask},
                                                       5, bus_b.mode)});
            exp_vld_a = 1'b0;
            if (qa.size() > 0 && qa[0].due == cyc + 1) begin
                exp_vld_a = 1'b1;
                exp_out_a = qa[0].val;
                void'(qa.pop_front());
            end
            exp_vld_b = 1'b0;
            if (qb.size() > 0 && qb[0].due == cyc + 1) begin
                exp_vld_b = 1'b1;
                exp_out_b = qb[0].val;
                void'(qb.pop_front());
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_eq("a_out_valid", bus_a.out_valid, exp_vld_a);
        check_eq("a_out",       bus_a.out,       exp_out_a);
        check_eq("a_acc_out",   bus_a.acc_out,   exp_acc_a);
        check_eq("b_out_valid", bus_b.out_valid, exp_vld_b);
        check_eq("b_out",       bus_b.out,       exp_out_b);
        check_eq("b_acc_out",   bus_b.acc_out,   exp_acc_b);
    endtask

    task automatic drive_a(input bit v, input logic [15:0] d, input logic [15:0] m,
                           input logic [1:0] md, input bit en, input bit clr);
        bus_a.in_valid = v;
        bus_a.in_data  = d;
        bus_a.in_mask  = m;
        bus_a.mode     = md;
        bus_a.acc_en   = en;
        bus_a.acc_clr  = clr;
    endtask

    task automatic drive_b(input bit v, input logic [4:0] d, input logic [4:0] m,
                           input logic [1:0] md, input bit en, input bit clr);
        bus_b.in_valid = v;
        bus_b.in_data  = d;
        bus_b.in_mask  = m;
        bus_b.mode     = md;
        bus_b.acc_en   = en;
        bus_b.acc_clr  = clr;
    endtask

    task automatic idle(input int n);
        drive_a(1'b0, '0, '0, 2'd0, 1'b0, 1'b0);
        drive_b(1'b0, '0, '0, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(5);

        // single OR, then the same with the set bit masked off
        drive_a(1'b1, 16'h0100, 16'hFFFF, 2'd0, 1'b0, 1'b0); tick();
        idle(3);
        drive_a(1'b1, 16'h0100, 16'hFEFF, 2'd0, 1'b0, 1'b0); tick();
        idle(3);

        // back-to-back with a mode change each cycle
        drive_a(1'b1, 16'hFFFF, 16'hFFFF, 2'd1, 1'b0, 1'b0); tick();
        drive_a(1'b1, 16'h0007, 16'hFFFF, 2'd2, 1'b0, 1'b0); tick();
        drive_a(1'b1, 16'h0000, 16'hFFFF, 2'd3, 1'b0, 1'b0); tick();
        idle(3);

        // all-masked vectors in every mode
        for (int md = 0; md < 4; md++) begin
            drive_a(1'b1, 16'($urandom()), 16'h0000, 2'(md), 1'b0, 1'b0);
            drive_b(1'b1, 5'($urandom()), 5'h00, 2'(md), 1'b0, 1'b0);
            tick();
        end
        idle(3);

        // accumulator: OR results 0,1,0 folded in, then clear alone
        drive_a(1'b1, 16'h0000, 16'hFFFF, 2'd0, 1'b1, 1'b0); tick();
        drive_a(1'b1, 16'h0001, 16'hFFFF, 2'd0, 1'b1, 1'b0); tick();
        drive_a(1'b1, 16'h0000, 16'hFFFF, 2'd0, 1'b1, 1'b0); tick();
        drive_a(1'b0, 16'h0000, 16'hFFFF, 2'd0, 1'b1, 1'b0); tick(); tick(); tick();
        drive_a(1'b0, 16'h0000, 16'hFFFF, 2'd0, 1'b0, 1'b1); tick();
        idle(1);
        // clear coincident with an emerging 1 and acc_en
        drive_a(1'b1, 16'h8000, 16'hFFFF, 2'd0, 1'b0, 1'b0); tick();
        idle(1);
        drive_a(1'b0, 16'h0000, 16'h0000, 2'd0, 1'b1, 1'b1); tick();
        idle(2);

        // non-power-of-four width, combinational tree
        drive_b(1'b1, 5'h1F, 5'h1F, 2'd1, 1'b0, 1'b0); tick();
        drive_b(1'b1, 5'h10, 5'h1F, 2'd2, 1'b0, 1'b0); tick();
        idle(2);

        // reset on the cycle after issue discards the transaction
        drive_a(1'b1, 16'hFFFF, 16'hFFFF, 2'd0, 1'b0, 1'b0); tick();
        idle(0);
        rst = 1'b1; tick();
        rst = 1'b0;
        idle(4);

        for (int i = 0; i < 500; i++) begin
            logic [15:0] ma;
            logic [4:0]  mb;
            case ($urandom_range(0, 3))
                0:       begin ma = 16'hFFFF; mb = 5'h1F; end
                1:       begin ma = 16'h0000; mb = 5'h00; end
                default: begin ma = 16'($urandom()); mb = 5'($urandom()); end
            endcase
            drive_a($urandom_range(0, 3) != 0, ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom()),
                    ma, 2'($urandom()), 1'($urandom()), $urandom_range(0, 7) == 0);
            drive_b($urandom_range(0, 3) != 0, ($urandom_range(0, 3) == 0) ? 5'h1F : 5'($urandom()),
                    mb, 2'($urandom()), 1'($urandom()), $urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 1'b0;
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
